dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, max consecutive contested CPU wins before a forced DMA grant (range 1..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cpu_req / cpu_we  input  1 / 1  MEM-stage access request / write (1) vs read (0).
REQ-005 cpu_addr / cpu_wdata  input  32 / 32  MEM-stage byte address / store data.
REQ-006 cpu_be  input  4  MEM-stage byte enables, already shifted by addr[1:0].
REQ-007 cpu_gnt  output  1  request accepted this cycle; when 0 the pipeline stalls MEM.
REQ-008 cpu_rvalid / cpu_rdata  output  1 / 32  read response to the CPU.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_be  input  1,1,32,32,4  DMA/debug port, same meanings as the CPU port.
REQ-010 dma_lock  input  1  hold ownership across back-to-back DMA beats.
REQ-011 dma_gnt / dma_rvalid / dma_rdata  output  1 / 1 / 32  DMA accept / read response.
REQ-012 mem_addr, mem_write_data, mem_byte_enable  output  32,32,4  registered data-memory address, data and enables.
REQ-013 mem_write_en / mem_read_en  output  1 / 1  registered data-memory strobes.
REQ-014 mem_read_data_in  input  32  data-memory read data, valid in the cycle mem_read_en is high.

Function
REQ-015 Owner FSM states: IDLE (no access issued), CPU (CPU access on port), DMA (DMA access on port); the state is the owner of the access registered at the last edge.
REQ-016 Grant is combinational from the current requests and state; at most one of cpu_gnt and dma_gnt is high per cycle; a grant is never given without its req.
REQ-017 Priority: CPU wins contention, except (a) state==DMA and dma_lock==1 and dma_req==1 (lock hold), or (b) the starvation counter equals STARVE_LIMIT.
REQ-018 On the edge after a grant, mem_* load the winner's addr/wdata/be, mem_write_en=we and mem_read_en=~we, and the FSM moves to the winner's state.
REQ-019 With no grant, the FSM moves to IDLE and mem_write_en=mem_read_en=0; mem_addr, mem_write_data and mem_byte_enable hold their values.
REQ-020 Read latency is 1: for a read granted in cycle N, the owner's rvalid is high in cycle N+1 with rdata=mem_read_data_in; writes return no rvalid.
REQ-021 Back-to-back accesses, including write-after-read and owner switches in consecutive cycles, run with no bubble.
REQ-022 The rvalid of a non-owner is 0; its rdata is 0 whenever its rvalid is 0.
REQ-023 Starvation counter, 8 bits: increments when both req are high and the CPU wins; clears on any DMA grant or when dma_req==0; saturates at STARVE_LIMIT.
REQ-024 Simultaneous lock hold and counter limit: the DMA wins; a lock held with dma_req==0 is ignored.

Reset
REQ-025 While rst_n==0: state=IDLE, counter=0, all mem_* outputs 0, and cpu_gnt, dma_gnt, cpu_rvalid and dma_rvalid are 0.
REQ-026 Reset asserted mid-access discards the in-flight access; no rvalid is issued for it after release.
REQ-027 First grant possible in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_GUARD_EN, when defined, compiles in the counter and rule REQ-017(b).
REQ-029 Without DMEM_ARB_STARVE_GUARD_EN, the counter is absent, the CPU always wins contention except under lock hold, and STARVE_LIMIT is unused.

Verification
REQ-030 CPU read only: cpu_req=1, we=0, addr=0x100 -> cpu_gnt=1 same cycle; mem_read_en=1, mem_addr=0x100 next cycle; cpu_rvalid=1 with the memory word next cycle.
REQ-031 Contention: both req=1 continuously, guard enabled, STARVE_LIMIT=8 -> CPU granted 8 cycles, DMA granted in cycle 9, then CPU again.
REQ-032 Lock: DMA owns the port, dma_lock=1, four DMA writes with cpu_req=1 -> four consecutive dma_gnt, cpu_gnt=0 throughout, CPU granted on the 5th cycle.
REQ-033 Owner switch: CPU read at N, DMA read at N+1 -> cpu_rvalid at N+1, dma_rvalid at N+2, no bubble, correct rdata for each.
REQ-034 Reset: assert rst_n=0 in the cycle after a CPU read grant -> mem_read_en=0 and cpu_rvalid=0 immediately; no rvalid after release.
REQ-035 Guard disabled: both req=1 for 20 cycles -> dma_gnt=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: groups the CPU port, the DMA/debug port and the data-memory
// port of dmem_arbiter. The arbiter connects through the slave modport; the
// environment driving requests and modelling memory uses the master modport.
interface dmem_arbiter_if;
    // CPU (MEM-stage) port
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    // DMA/debug port
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_be;
    logic        dma_lock;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    // Data-memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_read_data_in;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_write_data, mem_byte_enable, mem_write_en, mem_read_en,
        input  mem_read_data_in
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_write_data, mem_byte_enable, mem_write_en, mem_read_en,
        output mem_read_data_in
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (CPU, DMA) arbiter in front of a single-port data
// memory. Grants are combinational, the memory port is registered, and read
// data returns one cycle after the access is issued.
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to compile in the DMA
// starvation counter that forces a DMA grant after STARVE_LIMIT contested CPU
// wins. Without it the CPU wins every contention except a DMA lock hold.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_lock_hold;
    logic        w_starve;
    logic        w_cpu_rvalid;
    logic        w_dma_rvalid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_mem_we;
    logic        r_mem_re;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    // The DMA keeps the port only while it already owns it and is still requesting.
    assign w_lock_hold = (r_state == ST_DMA) && bus.dma_lock && bus.dma_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;

    assign w_starve = (r_starve_cnt == LP_LIMIT);

    // Count contested CPU wins; any DMA grant or an idle DMA request clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 8'd0;
        end else if (w_dma_gnt || !bus.dma_req) begin
            r_starve_cnt <= 8'd0;
        end else if (w_cpu_gnt && r_starve_cnt != LP_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    // Owner state register: remembers who issued the access now on the memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant decision and next owner, from the current requests and owner.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_state_next = ST_IDLE;
        // Grants are gated by rst_n so nothing is accepted while reset is held.
        if (rst_n) begin
            if (bus.dma_req && (!bus.cpu_req || w_lock_hold || w_starve)) begin
                w_dma_gnt    = 1'b1;
                w_state_next = ST_DMA;
            end else if (bus.cpu_req) begin
                w_cpu_gnt    = 1'b1;
                w_state_next = ST_CPU;
            end
        end
    end

    // Memory port registers: load the winner's access; strobes drop without a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else if (w_cpu_gnt) begin
            r_mem_addr  <= bus.cpu_addr;
            r_mem_wdata <= bus.cpu_wdata;
            r_mem_be    <= bus.cpu_be;
            r_mem_we    <= bus.cpu_we;
            r_mem_re    <= !bus.cpu_we;
        end else if (w_dma_gnt) begin
            r_mem_addr  <= bus.dma_addr;
            r_mem_wdata <= bus.dma_wdata;
            r_mem_be    <= bus.dma_be;
            r_mem_we    <= bus.dma_we;
            r_mem_re    <= !bus.dma_we;
        end else begin
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end
    end

    // A read on the port belongs to whoever owns it; the other side sees zeros.
    assign w_cpu_rvalid = r_mem_re && (r_state == ST_CPU);
    assign w_dma_rvalid = r_mem_re && (r_state == ST_DMA);

    assign bus.cpu_gnt         = w_cpu_gnt;
    assign bus.dma_gnt         = w_dma_gnt;
    assign bus.cpu_rvalid      = w_cpu_rvalid;
    assign bus.dma_rvalid      = w_dma_rvalid;
    assign bus.cpu_rdata       = w_cpu_rvalid ? bus.mem_read_data_in : 32'd0;
    assign bus.dma_rdata       = w_dma_rvalid ? bus.mem_read_data_in : 32'd0;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_write_data  = r_mem_wdata;
    assign bus.mem_byte_enable = r_mem_be;
    assign bus.mem_write_en    = r_mem_we;
    assign bus.mem_read_en     = r_mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run of dmem_arbiter,
// compared against a transaction-level model of the arbitration rules.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the access issued at the last edge, the contested-win
    // count, and the contents of the memory port.
    int          m_owner;   // 0 none, 1 CPU, 2 DMA
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_we;
    logic        m_re;

    function automatic void model_reset();
        m_owner = 0; m_cnt = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0; m_re = 1'b0;
    endfunction

    // Who should be granted given the requests on the bus right now.
    function automatic void model_grant(output bit cg, output bit dg);
        bit lock_hold;
        bit starve;
        lock_hold = (m_owner == 2) && bus.dma_lock && bus.dma_req;
        starve    = GUARD && (m_cnt == LIMIT);
        cg = 1'b0;
        dg = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
            if (lock_hold || starve) dg = 1'b1;
            else                     cg = 1'b1;
        end else if (bus.cpu_req) begin
            cg = 1'b1;
        end else if (bus.dma_req) begin
            dg = 1'b1;
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_commit();
        bit cg, dg;
        model_grant(cg, dg);
        if (dg || !bus.dma_req)            m_cnt = 0;
        else if (cg && m_cnt < LIMIT)      m_cnt = m_cnt + 1;
        if (cg) begin
            m_owner = 1; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata; m_be = bus.cpu_be;
            m_we = bus.cpu_we; m_re = !bus.cpu_we;
        end else if (dg) begin
            m_owner = 2; m_addr = bus.dma_addr; m_wdata = bus.dma_wdata; m_be = bus.dma_be;
            m_we = bus.dma_we; m_re = !bus.dma_we;
        end else begin
            m_owner = 0; m_we = 1'b0; m_re = 1'b0;
        end
    endfunction

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic [3:0] cbe,
                         input logic dreq, input logic dwe, input logic [31:0] daddr,
                         input logic [31:0] dwd, input logic [3:0] dbe, input logic dlock);
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd; bus.cpu_be = cbe;
        bus.dma_req = dreq; bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd; bus.dma_be = dbe;
        bus.dma_lock = dlock;
        bus.mem_read_data_in = $urandom();
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 32'h40, '0, 4'hF, 1'b1, 1'b0, 32'h80, '0, 4'hF, 1'b1);
        n_checks++;
        if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b00) begin
            n_errors++; $display("FAIL reset_gnt: got %b expected 00", {bus.cpu_gnt, bus.dma_gnt});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_write_data, bus.mem_byte_enable, bus.mem_write_en, bus.mem_read_en} !== 70'd0) begin
            n_errors++; $display("FAIL reset_mem: addr %h wdata %h be %h we %b re %b expected all 0",
                bus.mem_addr, bus.mem_write_data, bus.mem_byte_enable, bus.mem_write_en, bus.mem_read_en);
        end
        n_checks++;
        if ({bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata} !== 66'd0) begin
            n_errors++; $display("FAIL reset_resp: rvalid %b%b expected 00", bus.cpu_rvalid, bus.dma_rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Runs in the first cycle after reset release, so it also shows the first grant is immediate.
    task automatic test_cpu_read();
        logic [31:0] word;
        drive(1'b1, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        n_checks++;
        if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL cpu_read_gnt: got %b expected 10", {bus.cpu_gnt, bus.dma_gnt});
        end
        tick();
        drive_idle();
        word = bus.mem_read_data_in;
        n_checks++;
        if ({bus.mem_read_en, bus.mem_write_en, bus.mem_addr} !== {2'b10, 32'h100}) begin
            n_errors++; $display("FAIL cpu_read_port: re %b we %b addr %h expected re 1 we 0 addr 00000100",
                bus.mem_read_en, bus.mem_write_en, bus.mem_addr);
        end
        n_checks++;
        if ({bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid} !== {1'b1, word, 1'b0}) begin
            n_errors++; $display("FAIL cpu_read_resp: rvalid %b rdata %h dma_rvalid %b expected 1 %h 0",
                bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, word);
        end
        tick();
    endtask

    task automatic test_contention();
        int  n;
        bit  exp_dma;
        drive_idle();
        tick();
        n = GUARD ? LIMIT + 2 : 20;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, $urandom(), '0, 4'hF, 1'b1, 1'b0, $urandom(), '0, 4'hF, 1'b0);
            exp_dma = GUARD && (i == LIMIT);
            n_checks++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== {!exp_dma, exp_dma}) begin
                n_errors++; $display("FAIL contention_cycle%0d: got %b expected %b", i,
                    {bus.cpu_gnt, bus.dma_gnt}, {!exp_dma, exp_dma});
            end
            tick();
        end
    endtask

    task automatic test_lock();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 32'h200, 32'hA0, 4'hF, 1'b1);
        n_checks++;
        if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL lock_setup: got %b expected 01", {bus.cpu_gnt, bus.dma_gnt});
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h300, '0, 4'hF, 1'b1, 1'b1, 32'h204 + 32'(4 * k), 32'(k), 4'hF, 1'b1);
            n_checks++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_write_en} !== 3'b011) begin
                n_errors++; $display("FAIL lock_beat%0d: gnt %b mem_write_en %b expected 01 1", k,
                    {bus.cpu_gnt, bus.dma_gnt}, bus.mem_write_en);
            end
            tick();
        end
        drive(1'b1, 1'b0, 32'h300, '0, 4'hF, 1'b0, 1'b1, 32'h214, '0, 4'hF, 1'b1);
        n_checks++;
        if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL lock_release: got %b expected 10", {bus.cpu_gnt, bus.dma_gnt});
        end
        tick();
    endtask

    task automatic test_owner_switch();
        logic [31:0] word;
        drive(1'b1, 1'b0, 32'h400, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h500, '0, 4'h3, 1'b0);
        word = bus.mem_read_data_in;
        n_checks++;
        if ({bus.dma_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.mem_addr} !== {2'b11, word, 1'b0, 32'h400}) begin
            n_errors++; $display("FAIL switch_n1: dma_gnt %b cpu_rvalid %b cpu_rdata %h dma_rvalid %b addr %h expected 1 1 %h 0 00000400",
                bus.dma_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.mem_addr, word);
        end
        tick();
        drive_idle();
        word = bus.mem_read_data_in;
        n_checks++;
        if ({bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_addr, bus.mem_read_en}
                !== {1'b1, word, 1'b0, 32'd0, 32'h500, 1'b1}) begin
            n_errors++; $display("FAIL switch_n2: dma_rvalid %b dma_rdata %h cpu_rvalid %b cpu_rdata %h addr %h re %b expected 1 %h 0 0 00000500 1",
                bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid, bus.cpu_rdata, bus.mem_addr, bus.mem_read_en, word);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 32'h600, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        rst_n = 1'b0;
        drive_idle();
        n_checks++;
        if ({bus.mem_read_en, bus.cpu_rvalid, bus.cpu_gnt} !== 3'b000) begin
            n_errors++; $display("FAIL reset_mid: re %b cpu_rvalid %b cpu_gnt %b expected 0 0 0",
                bus.mem_read_en, bus.cpu_rvalid, bus.cpu_gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            n_checks++;
            if ({bus.cpu_rvalid, bus.dma_rvalid, bus.mem_read_en} !== 3'b000) begin
                n_errors++; $display("FAIL reset_mid_after%0d: rvalid %b%b re %b expected 00 0", i,
                    bus.cpu_rvalid, bus.dma_rvalid, bus.mem_read_en);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit          cg, dg, ecv, edv;
        int          dprob;
        for (int i = 0; i < 400; i++) begin
            dprob = ((i / 40) % 2 == 1) ? 95 : 50;
            drive(1'($urandom_range(99) < 70), 1'($urandom_range(1)), $urandom(), $urandom(), 4'($urandom()),
                  1'($urandom_range(99) < dprob), 1'($urandom_range(1)), $urandom(), $urandom(), 4'($urandom()),
                  1'($urandom_range(3) != 0));
            model_grant(cg, dg);
            ecv = m_re && (m_owner == 1);
            edv = m_re && (m_owner == 2);
            n_checks++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== {cg, dg}) begin
                n_errors++; $display("FAIL rand%0d_gnt: got %b expected %b", i, {bus.cpu_gnt, bus.dma_gnt}, {cg, dg});
            end
            n_checks++;
            if ({bus.mem_addr, bus.mem_write_data, bus.mem_byte_enable, bus.mem_write_en, bus.mem_read_en}
                    !== {m_addr, m_wdata, m_be, m_we, m_re}) begin
                n_errors++; $display("FAIL rand%0d_mem: got %h %h %h %b %b expected %h %h %h %b %b", i,
                    bus.mem_addr, bus.mem_write_data, bus.mem_byte_enable, bus.mem_write_en, bus.mem_read_en,
                    m_addr, m_wdata, m_be, m_we, m_re);
            end
            n_checks++;
            if ({bus.cpu_rvalid, bus.cpu_rdata} !== {ecv, ecv ? bus.mem_read_data_in : 32'd0}) begin
                n_errors++; $display("FAIL rand%0d_cpu_resp: got %b %h expected %b", i, bus.cpu_rvalid, bus.cpu_rdata, ecv);
            end
            n_checks++;
            if ({bus.dma_rvalid, bus.dma_rdata} !== {edv, edv ? bus.mem_read_data_in : 32'd0}) begin
                n_errors++; $display("FAIL rand%0d_dma_resp: got %b %h expected %b", i, bus.dma_rvalid, bus.dma_rdata, edv);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_read();
        test_contention();
        test_lock();
        test_owner_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
